// File: rtl/avalon_param_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_param_interval_timer
//  Description : Avalon-MM interval timer with a software-writable period.
//                It counts down, raises a maskable timeout IRQ, and runs in
//                one-shot or continuous mode with software START/STOP.
//                Optional counter snapshot when TIMER_SNAPSHOT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_param_interval_timer #(
    parameter int          COUNTER_WIDTH = 32,
    parameter logic [31:0] RESET_PERIOD  = 32'h042C1D7F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        chipselect,
    input  logic [2:0]  address,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    localparam int                       c_HI_W      = COUNTER_WIDTH - 16;
    localparam logic [COUNTER_WIDTH-1:0] c_RESET_VAL = RESET_PERIOD[COUNTER_WIDTH-1:0];

    localparam logic [2:0] c_ADDR_STATUS  = 3'd0;
    localparam logic [2:0] c_ADDR_CONTROL = 3'd1;
    localparam logic [2:0] c_ADDR_PERIODL = 3'd2;
    localparam logic [2:0] c_ADDR_PERIODH = 3'd3;
    localparam logic [2:0] c_ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] c_ADDR_SNAPH   = 3'd5;

    logic [COUNTER_WIDTH-1:0] r_counter;
    logic [COUNTER_WIDTH-1:0] r_period;
    logic                     r_run;
    logic                     r_to;
    logic                     r_ito;
    logic                     r_cont;

    logic                     w_wr;
    logic                     w_wr_status;
    logic                     w_wr_control;
    logic                     w_wr_periodl;
    logic                     w_wr_periodh;
    logic                     w_period_wr;
    logic                     w_start;
    logic                     w_stop;
    logic                     w_timeout;
    logic [COUNTER_WIDTH-1:0] w_period_next;
    logic [COUNTER_WIDTH-1:0] w_counter_next;
    logic                     w_run_next;
    logic                     w_to_next;
    logic [15:0]              w_rdata;

    // Bus write decode
    assign w_wr         = chipselect & ~write_n;
    assign w_wr_status  = w_wr && (address == c_ADDR_STATUS);
    assign w_wr_control = w_wr && (address == c_ADDR_CONTROL);
    assign w_wr_periodl = w_wr && (address == c_ADDR_PERIODL);
    assign w_wr_periodh = w_wr && (address == c_ADDR_PERIODH);
    assign w_period_wr  = w_wr_periodl | w_wr_periodh;
    assign w_start      = w_wr_control & writedata[2];
    assign w_stop       = w_wr_control & writedata[3];
    assign w_timeout    = r_run && (r_counter == '0);

    // Merge the written half into the current period
    always_comb begin
        w_period_next = r_period;
        if (w_wr_periodl) begin
            w_period_next[15:0] = writedata;
        end
        if (w_wr_periodh) begin
            w_period_next[COUNTER_WIDTH-1:16] = writedata[c_HI_W-1:0];
        end
    end

    // Counter update: a period write overrides everything; a STOP edge freezes
    // the count except that a pending zero-count reload still happens
    always_comb begin
        w_counter_next = r_counter;
        if (w_period_wr) begin
            w_counter_next = w_period_next;
        end else if (w_timeout) begin
            w_counter_next = r_period;
        end else if (r_run && !w_stop) begin
            w_counter_next = r_counter - 1'b1;
        end
    end

    // RUN update: period write and STOP clear it, START only acts when idle
    always_comb begin
        w_run_next = r_run;
        if (w_period_wr || w_stop) begin
            w_run_next = 1'b0;
        end else if (w_start && !r_run) begin
            w_run_next = 1'b1;
        end else if (w_timeout) begin
            w_run_next = r_cont;
        end
    end

    // TO update: a timeout on the same edge as a clear wins so no event is lost
    always_comb begin
        w_to_next = r_to;
        if (w_timeout) begin
            w_to_next = 1'b1;
        end else if (w_wr_status) begin
            w_to_next = 1'b0;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_counter <= c_RESET_VAL;
            r_period  <= c_RESET_VAL;
            r_run     <= 1'b0;
            r_to      <= 1'b0;
            r_ito     <= 1'b0;
            r_cont    <= 1'b0;
        end else begin
            r_counter <= w_counter_next;
            r_period  <= w_period_next;
            r_run     <= w_run_next;
            r_to      <= w_to_next;
            if (w_wr_control) begin
                r_ito  <= writedata[0];
                r_cont <= writedata[1];
            end
        end
    end

`ifdef TIMER_SNAPSHOT_EN
    logic [COUNTER_WIDTH-1:0] r_snapshot;

    // Snapshot captures the counter value being loaded at the write edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_snapshot <= '0;
        end else if (w_wr && ((address == c_ADDR_SNAPL) || (address == c_ADDR_SNAPH))) begin
            r_snapshot <= w_counter_next;
        end
    end
`endif

    // Read data multiplexer
    always_comb begin
        w_rdata = 16'h0000;
        case (address)
            c_ADDR_STATUS:  w_rdata = {14'b0, r_run, r_to};
            c_ADDR_CONTROL: w_rdata = {14'b0, r_cont, r_ito};
            c_ADDR_PERIODL: w_rdata = r_period[15:0];
            c_ADDR_PERIODH: w_rdata = 16'(r_period[COUNTER_WIDTH-1:16]);
`ifdef TIMER_SNAPSHOT_EN
            c_ADDR_SNAPL:   w_rdata = r_snapshot[15:0];
            c_ADDR_SNAPH:   w_rdata = 16'(r_snapshot[COUNTER_WIDTH-1:16]);
`endif
            default:        w_rdata = 16'h0000;
        endcase
    end

    // Registered read data, one cycle of latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 16'h0000;
        end else begin
            readdata <= w_rdata;
        end
    end

    assign irq = r_to & r_ito;

endmodule
`default_nettype wire

// File: tb/tb_avalon_param_interval_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_param_interval_timer
//  Description : Directed, table-driven bench for the interval timer. A
//                second instance with COUNTER_WIDTH=17 covers the narrow
//                PERIODH read-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_param_interval_timer;

    localparam int K_WR   = 0;  // bus write to DUT
    localparam int K_RD   = 1;  // bus read, compare readdata
    localparam int K_IDLE = 2;  // idle for data cycles
    localparam int K_IRQ  = 3;  // compare irq
    localparam int K_NCS  = 4;  // write strobe without chipselect

    typedef struct {
        int          kind;
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs1;
    logic        cs2;
    logic        write_n;
    logic [2:0]  address;
    logic [15:0] writedata;
    logic [15:0] rd1;
    logic [15:0] rd2;
    logic        irq1;
    logic        irq2;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    avalon_param_interval_timer u_dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (cs1),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd1),
        .irq        (irq1)
    );

    avalon_param_interval_timer #(.COUNTER_WIDTH(17)) u_dut17 (
        .clk        (clk),
        .reset_n    (reset_n),
        .chipselect (cs2),
        .address    (address),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd2),
        .irq        (irq2)
    );

    function automatic void add(int k, int a, int d, int e);
        vec_t v;
        v.kind = k;
        v.addr = 3'(a);
        v.data = 16'(d);
        v.exp  = 16'(e);
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [15:0] act, logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, take one rising edge, release strobes
    task automatic bus(logic c1, logic c2, logic wn, logic [2:0] a, logic [15:0] d);
        cs1       = c1;
        cs2       = c2;
        write_n   = wn;
        address   = a;
        writedata = d;
        @(posedge clk);
        #1;
        cs1     = 1'b0;
        cs2     = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic run_vec(vec_t v, int i);
        case (v.kind)
            K_WR:   bus(1'b1, 1'b0, 1'b0, v.addr, v.data);
            K_RD: begin
                bus(1'b1, 1'b0, 1'b1, v.addr, 16'h0);
                check($sformatf("vec%0d read a%0d", i, v.addr), rd1, v.exp);
            end
            K_IDLE: begin
                repeat (int'(v.data)) begin
                    @(posedge clk);
                    #1;
                end
            end
            K_IRQ:  check($sformatf("vec%0d irq", i), {15'b0, irq1}, v.exp);
            K_NCS:  bus(1'b0, 1'b0, 1'b0, v.addr, v.data);
            default: ;
        endcase
    endtask

    initial begin
        // Reset state after release
        add(K_IRQ, 0, 0, 0);
        add(K_RD, 0, 0, 16'h0000);
        add(K_RD, 2, 0, 16'h1D7F);
        add(K_RD, 3, 0, 16'h042C);
        add(K_RD, 1, 0, 16'h0000);
        add(K_RD, 4, 0, 16'h0000);
        add(K_RD, 5, 0, 16'h0000);
        add(K_WR, 6, 16'hFFFF, 0);
        add(K_RD, 6, 0, 16'h0000);
        add(K_NCS, 2, 16'h1234, 0);
        add(K_RD, 2, 0, 16'h1D7F);
        // One-shot, period 4: timeout after S+5
        add(K_WR, 2, 4, 0);
        add(K_WR, 3, 0, 0);
        add(K_WR, 1, 5, 0);
        add(K_IRQ, 0, 0, 0);
        add(K_RD, 0, 0, 16'h0002);
        add(K_IDLE, 0, 3, 0);
        add(K_IRQ, 0, 0, 0);
        add(K_IDLE, 0, 1, 0);
        add(K_IRQ, 0, 0, 1);
        add(K_RD, 0, 0, 16'h0001);
        add(K_WR, 0, 0, 0);
        add(K_IRQ, 0, 0, 0);
        add(K_RD, 1, 0, 16'h0001);
        // Restart from the reloaded counter (4)
        add(K_WR, 1, 5, 0);
        add(K_IDLE, 0, 4, 0);
        add(K_IRQ, 0, 0, 0);
        add(K_IDLE, 0, 1, 0);
        add(K_IRQ, 0, 0, 1);
        // Continuous, period 2: timeouts at S+3, S+6
        add(K_WR, 0, 0, 0);
        add(K_WR, 2, 2, 0);
        add(K_WR, 1, 7, 0);
        add(K_RD, 0, 0, 16'h0002);
        add(K_IDLE, 0, 1, 0);
        add(K_IRQ, 0, 0, 0);
        add(K_IDLE, 0, 1, 0);
        add(K_IRQ, 0, 0, 1);
        add(K_WR, 0, 0, 0);
        add(K_IRQ, 0, 0, 0);
        add(K_IDLE, 0, 1, 0);
        add(K_IRQ, 0, 0, 0);
        add(K_WR, 0, 0, 0);            // clear on the S+6 timeout edge
        add(K_IRQ, 0, 0, 1);
        add(K_RD, 0, 0, 16'h0003);
        add(K_RD, 1, 0, 16'h0003);
        // STOP/START: period 10, stop with counter at 7, resume without reload
        add(K_WR, 2, 10, 0);
        add(K_WR, 0, 0, 0);
        add(K_WR, 1, 6, 0);
        add(K_IDLE, 0, 3, 0);
        add(K_WR, 1, 16'hC, 0);        // START+STOP: STOP wins
        add(K_RD, 0, 0, 16'h0000);
        add(K_IDLE, 0, 20, 0);
        add(K_RD, 0, 0, 16'h0000);
        add(K_WR, 1, 5, 0);            // resume at R
        add(K_IDLE, 0, 1, 0);
        add(K_WR, 1, 5, 0);            // START while running: ignored
        add(K_IDLE, 0, 4, 0);
        add(K_IRQ, 0, 0, 0);
        add(K_IDLE, 0, 1, 0);
        add(K_IRQ, 0, 0, 0);
        add(K_IDLE, 0, 1, 0);
        add(K_IRQ, 0, 0, 1);           // R+8
        add(K_RD, 0, 0, 16'h0001);
        // Period write while running stops and reloads
        add(K_WR, 0, 0, 0);
        add(K_WR, 1, 7, 0);
        add(K_IDLE, 0, 2, 0);
        add(K_WR, 2, 3, 0);
        add(K_RD, 0, 0, 16'h0000);
        add(K_IRQ, 0, 0, 0);
        add(K_WR, 1, 5, 0);
        add(K_IDLE, 0, 3, 0);
        add(K_IRQ, 0, 0, 0);
        add(K_IDLE, 0, 1, 0);
        add(K_IRQ, 0, 0, 1);
        // period 0: continuous timeout every clock, then one-shot
        add(K_WR, 2, 0, 0);
        add(K_WR, 0, 0, 0);
        add(K_WR, 1, 7, 0);
        add(K_WR, 0, 0, 0);
        add(K_IRQ, 0, 0, 1);
        add(K_RD, 0, 0, 16'h0003);
        add(K_WR, 1, 1, 0);
        add(K_IDLE, 0, 1, 0);
        add(K_RD, 0, 0, 16'h0001);
        add(K_WR, 0, 0, 0);
        add(K_WR, 1, 5, 0);
        add(K_RD, 0, 0, 16'h0002);
        add(K_RD, 0, 0, 16'h0001);
        add(K_IRQ, 0, 0, 1);

        reset_n   = 1'b0;
        cs1       = 1'b0;
        cs2       = 1'b0;
        write_n   = 1'b1;
        address   = 3'd0;
        writedata = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check("reset readdata", rd1, 16'h0000);
        check("reset irq", {15'b0, irq1}, 16'h0000);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

`ifdef TIMER_SNAPSHOT_EN
        // Snapshot 10 edges after START with period 100
        bus(1'b1, 1'b0, 1'b0, 3'd2, 16'd100);
        bus(1'b1, 1'b0, 1'b0, 3'd1, 16'h0004);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        bus(1'b1, 1'b0, 1'b0, 3'd4, 16'h0000);
        bus(1'b1, 1'b0, 1'b1, 3'd4, 16'h0000);
        check("snapl", rd1, 16'd90);
        bus(1'b1, 1'b0, 1'b1, 3'd5, 16'h0000);
        check("snaph", rd1, 16'h0000);
`else
        bus(1'b1, 1'b0, 1'b0, 3'd4, 16'hFFFF);
        bus(1'b1, 1'b0, 1'b1, 3'd4, 16'h0000);
        check("snapl absent", rd1, 16'h0000);
        bus(1'b1, 1'b0, 1'b0, 3'd5, 16'hFFFF);
        bus(1'b1, 1'b0, 1'b1, 3'd5, 16'h0000);
        check("snaph absent", rd1, 16'h0000);
`endif

        // Asynchronous reset in the middle of a count
        bus(1'b1, 1'b0, 1'b0, 3'd2, 16'd50);
        bus(1'b1, 1'b0, 1'b0, 3'd1, 16'h0007);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        bus(1'b1, 1'b0, 1'b1, 3'd2, 16'h0000);
        check("pre-reset periodl", rd1, 16'h0032);
        check("pre-reset irq", {15'b0, irq1}, 16'h0001);
        #2;
        reset_n = 1'b0;
        #1;
        check("async reset readdata", rd1, 16'h0000);
        check("async reset irq", {15'b0, irq1}, 16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus(1'b1, 1'b0, 1'b1, 3'd0, 16'h0000);
        check("post-reset status", rd1, 16'h0000);
        bus(1'b1, 1'b0, 1'b1, 3'd2, 16'h0000);
        check("post-reset periodl", rd1, 16'h1D7F);
        bus(1'b1, 1'b0, 1'b1, 3'd1, 16'h0000);
        check("post-reset control", rd1, 16'h0000);

        // 17-bit instance: PERIODH holds only bit 16
        bus(1'b0, 1'b1, 1'b1, 3'd3, 16'h0000);
        check("w17 periodh reset", rd2, 16'h0000);
        bus(1'b0, 1'b1, 1'b1, 3'd2, 16'h0000);
        check("w17 periodl reset", rd2, 16'h1D7F);
        bus(1'b0, 1'b1, 1'b0, 3'd3, 16'hFFFF);
        bus(1'b0, 1'b1, 1'b1, 3'd3, 16'h0000);
        check("w17 periodh masked", rd2, 16'h0001);
        check("w17 irq", {15'b0, irq2}, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
